serial_word_receiver: RTL and testbench
=======================================

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, means clock cycles per serial bit period (legal range 4 to 1024).
REQ-002 Parameter DATA_BITS, default 4, means data bits per frame (legal range 1 to 16).
REQ-003 Inclk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-low reset (0 = in reset).
REQ-005 shr_in  input  1  is the asynchronous serial line, idle high.
REQ-006 rd_ack  input  1  is the consumer acknowledge; a 1 for one cycle consumes the held word.
REQ-007 rx_data  output  DATA_BITS  is the last correctly received word.
REQ-008 rx_valid  output  1  means rx_data holds an unconsumed word.
REQ-009 overrun  output  1  means a word was overwritten before it was consumed.
REQ-010 frame_err  output  1  is a one-cycle pulse for a frame with a bad stop bit.
REQ-011 busy  output  1  is high whenever the state machine is not IDLE.

Function
REQ-012 Frame format: one start bit (0), then DATA_BITS data bits LSB first, then one stop bit (1).
REQ-013 shr_in passes through a two-flop synchronizer before use; all timing below counts from the synchronized signal (line_s).
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE -> START occurs when line_s = 0; the bit counter loads CLKS_PER_BIT/2 - 1.
REQ-016 START at counter expiry: if line_s = 0, go to DATA with the counter at CLKS_PER_BIT-1; if line_s = 1, treat it as a glitch and return to IDLE with no outputs changed.
REQ-017 DATA samples line_s at each counter expiry (mid-bit) and shifts it in from the MSB side, so the first bit received ends up in bit 0.
REQ-018 DATA -> STOP occurs after the DATA_BITS-th sample.
REQ-019 STOP samples line_s at mid-bit, then returns to IDLE.
REQ-020 Good stop bit (1): rx_data updates and rx_valid = 1 on the cycle after the stop sample.
REQ-021 Bad stop bit (0): frame_err pulses for one cycle; rx_data, rx_valid and overrun are unchanged.
REQ-022 A good frame that completes while rx_valid = 1 and rd_ack = 0 sets overrun = 1 and overwrites rx_data.
REQ-023 rd_ack = 1 with no simultaneous completion clears rx_valid and overrun on the next cycle.
REQ-024 Completion and rd_ack = 1 in the same cycle: the new word loads, rx_valid stays 1, overrun is cleared and not set.
REQ-025 rd_ack while rx_valid = 0 is ignored.
REQ-026 After STOP, a start bit is accepted on the next cycle in IDLE, so back-to-back frames are supported.
REQ-027 Width rule: the bit counter is $clog2(CLKS_PER_BIT) bits wide and the data-bit index is $clog2(DATA_BITS+1) bits wide; no wrap-around occurs inside a frame.

Reset
REQ-028 reset = 0 asynchronously forces IDLE, rx_data = 0, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0, and both synchronizer flops to 1.
REQ-029 Reset asserted mid-frame discards the partial word; after release the receiver waits for a fresh falling edge.
REQ-030 Release of reset is the only synchronous event for reset; no output glitches to 1 during reset.

Structure
REQ-031 The state enum typedef and the default constants for CLKS_PER_BIT and DATA_BITS shall live in the shared package serial_pkg.
REQ-032 The two-flop synchronizer shall be the sub-module sync2 (ports Inclk, reset, d, q; reset value 1).
REQ-033 The shift register, counters and FSM shall be coded in the top module; there are no other sub-modules.

Verification (CLKS_PER_BIT=16, DATA_BITS=4)
REQ-034 Frame 0xA (line 0,0,1,0,1,1) -> rx_data=4'hA and rx_valid=1 exactly 2+8+16*5+1 cycles after the line falls; overrun=0.
REQ-035 Two back-to-back frames 0x3 then 0xC with no rd_ack -> rx_data=4'hC, rx_valid=1, overrun=1; one rd_ack -> both 0.
REQ-036 Stop bit driven 0 on frame 0x5 -> frame_err pulses once, rx_valid stays 0, and a following frame 0x6 is received correctly.
REQ-037 6-cycle low glitch on an idle line -> return to IDLE, no outputs change, busy high for fewer than 10 cycles.
REQ-038 reset asserted during the third data bit of frame 0xF -> all outputs 0 immediately; after release, frame 0x9 yields rx_data=4'h9.
REQ-039 rd_ack in the same cycle as frame 0x7 completes, while 0x1 is held -> rx_data=4'h7, rx_valid=1, overrun=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word receiver.
// Holds the receiver state encoding and the default framing constants.
// The top module and its users import these.
package serial_pkg;

  // Default framing: 16 clocks per serial bit, 4 data bits per frame
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 4;

  // Receiver state machine states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } RxState;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The flops reset to 1 because the serial line idles high.
// Without that, a spurious start bit would be seen as reset releases.
// Ports:
//   Inclk - clock
//   reset - asynchronous reset, active low
//   d     - asynchronous input
//   q     - synchronized output, two clocks behind d
module sync2 (
  input  logic Inclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // The first flop may go metastable.
  // The second flop gives it a full cycle to settle before q is used.
  always_ff @(posedge Inclk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver.
// Frame format: a start bit (0), DATA_BITS data bits sent LSB first, then a stop bit (1).
// Each bit is sampled at mid-bit using a down-counter.
// A good word is held for a consumer until it is acknowledged.
// Ports:
//   Inclk     - clock; all state changes on its rising edge
//   reset     - asynchronous reset, active low
//   shr_in    - asynchronous serial line, idles high
//   rd_ack    - one-cycle pulse that consumes the held word
//   rx_data   - last correctly received word
//   rx_valid  - rx_data holds a word that has not been consumed
//   overrun   - a held word was overwritten before it was consumed
//   frame_err - one-cycle pulse when a frame ends with a bad stop bit
//   busy      - high whenever the receiver is not idle
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 Inclk,
  input  logic                 reset,
  input  logic                 shr_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // The first reload lands in the middle of the start bit.
  // Every later reload spans one full bit, keeping the samples at mid-bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 w_lineS;
  logic                 w_expire;
  logic [DATA_BITS-1:0] w_shiftNext;

  RxState               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rxData;
  logic                 r_rxValid;
  logic                 r_overrun;
  logic                 r_frameErr;
  logic                 r_busy;

  sync2 u_sync (
    .Inclk (Inclk),
    .reset (reset),
    .d     (shr_in),
    .q     (w_lineS)
  );

  assign w_expire = (r_cnt == '0);

  // New bits enter at the MSB end and move toward bit 0.
  // After DATA_BITS samples, the first bit received sits in bit 0.
  always_comb begin
    w_shiftNext                = r_shift >> 1;
    w_shiftNext[DATA_BITS-1]   = w_lineS;
  end

  // Receiver FSM, bit timing, shift register and consumer handshake.
  // An acknowledge of a held word clears rx_valid and overrun.
  // A good frame completing in the same cycle overrides that clear.
  // Overrun is set only when the held word was not taken in that cycle.
  always_ff @(posedge Inclk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;

      if (rd_ack && r_rxValid) begin
        r_rxValid <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!w_lineS) begin
            r_state <= START;
            r_cnt   <= HALF_LOAD;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (w_expire) begin
            if (!w_lineS) begin
              r_state  <= DATA;
              r_cnt    <= FULL_LOAD;
              r_bitIdx <= '0;
            end else begin
              // The line went high again before mid-bit: treat it as a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        DATA: begin
          if (w_expire) begin
            r_shift <= w_shiftNext;
            r_cnt   <= FULL_LOAD;
            if (r_bitIdx == LAST_IDX) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        STOP: begin
          if (w_expire) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_lineS) begin
              r_rxData  <= r_shift;
              r_rxValid <= 1'b1;
              r_overrun <= r_rxValid & ~rd_ack;
            end else begin
              r_frameErr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_rxData;
  assign rx_valid  = r_rxValid;
  assign overrun   = r_overrun;
  assign frame_err = r_frameErr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver with CLKS_PER_BIT=16 and DATA_BITS=4.
// A behavioural model tracks the consumer-visible word.
// The model applies frame-level rules: a good frame loads the word,
// an acknowledge consumes it, and an unconsumed overwrite flags an overrun.
module tb_serial_word_receiver;

  localparam int CPB = 16;
  localparam int DB  = 4;
  localparam int FRAME_CYCLES = CPB * (DB + 2);
  localparam int DONE_EDGE    = 2 + 8 + CPB * (DB + 1) + 1;

  logic          clock = 1'b0;
  logic          resetN;
  logic          serialIn;
  logic          rdAck;
  logic [DB-1:0] rxData;
  logic          rxValid;
  logic          overrun;
  logic          frameErr;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [DB-1:0] expData;
  bit            expValid;
  bit            expOverrun;

  serial_word_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .Inclk     (clock),
    .reset     (resetN),
    .shr_in    (serialIn),
    .rd_ack    (rdAck),
    .rx_data   (rxData),
    .rx_valid  (rxValid),
    .overrun   (overrun),
    .frame_err (frameErr),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  // Line level at cycle n of a frame: start bit, data bits LSB first, then stop bit
  function automatic logic frameLevel(input logic [DB-1:0] w, input logic stopBit, input int n);
    int b;
    logic [1:0] idx;
    b = n / CPB;
    if (b == 0) return 1'b0;
    if (b <= DB) begin
      idx = 2'(b - 1);
      return w[idx];
    end
    return stopBit;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic doAck();
    rdAck = 1'b1;
    @(posedge clock);
    #1;
    rdAck = 1'b0;
    if (expValid) begin
      expValid   = 1'b0;
      expOverrun = 1'b0;
    end
  endtask

  // Drive one whole frame and capture rx_valid around the expected completion.
  // Optionally acknowledge in the completion cycle, then update the model.
  task automatic applyStimulus(input logic [DB-1:0] word, input bit stopBit, input bit ackAtDone,
                               output bit validAt90, output bit validAt91, output int errPulses);
    errPulses = 0;
    validAt90 = 1'b0;
    validAt91 = 1'b0;
    for (int n = 0; n < FRAME_CYCLES; n++) begin
      serialIn = frameLevel(word, stopBit, n);
      if (ackAtDone && n == DONE_EDGE - 1) rdAck = 1'b1;
      @(posedge clock);
      #1;
      if (n == DONE_EDGE - 1) rdAck = 1'b0;
      if (n + 1 == DONE_EDGE - 1) validAt90 = rxValid;
      if (n + 1 == DONE_EDGE) validAt91 = rxValid;
      if (frameErr) errPulses++;
    end
    serialIn = 1'b1;
    if (stopBit) begin
      expOverrun = expValid && !ackAtDone;
      expData    = word;
      expValid   = 1'b1;
    end else if (ackAtDone && expValid) begin
      expValid   = 1'b0;
      expOverrun = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    serialIn = 1'b1;
    rdAck    = 1'b0;
    expData = '0; expValid = 1'b0; expOverrun = 1'b0;
    idle(3);
    checks++; if (rxData !== 4'h0)   begin errors++; $display("[TB] FAIL reset.rx_data got=%h exp=0", rxData); end
    checks++; if (rxValid !== 1'b0)  begin errors++; $display("[TB] FAIL reset.rx_valid got=%b exp=0", rxValid); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("[TB] FAIL reset.overrun got=%b exp=0", overrun); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset.frame_err got=%b exp=0", frameErr); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset.busy got=%b exp=0", busy); end
    resetN = 1'b1;
    idle(5);
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset.idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_frame();
    bit v90, v91;
    int ep;
    applyStimulus(4'hA, 1'b1, 1'b0, v90, v91, ep);
    checks++; if (v90 !== 1'b0)       begin errors++; $display("[TB] FAIL single.valid_early got=%b exp=0", v90); end
    checks++; if (v91 !== 1'b1)       begin errors++; $display("[TB] FAIL single.valid_on_time got=%b exp=1", v91); end
    checks++; if (rxData !== expData) begin errors++; $display("[TB] FAIL single.rx_data got=%h exp=%h", rxData, expData); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL single.overrun got=%b exp=%b", overrun, expOverrun); end
    checks++; if (ep != 0)            begin errors++; $display("[TB] FAIL single.frame_err got=%0d exp=0", ep); end
    doAck();
    checks++; if (rxValid !== expValid) begin errors++; $display("[TB] FAIL single.ack_valid got=%b exp=%b", rxValid, expValid); end
  endtask

  task automatic test_back_to_back();
    bit v90, v91;
    int ep;
    applyStimulus(4'h3, 1'b1, 1'b0, v90, v91, ep);
    applyStimulus(4'hC, 1'b1, 1'b0, v90, v91, ep);
    checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL b2b.rx_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL b2b.rx_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL b2b.overrun got=%b exp=%b", overrun, expOverrun); end
    doAck();
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL b2b.ack_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL b2b.ack_overrun got=%b exp=%b", overrun, expOverrun); end
  endtask

  task automatic test_bad_stop();
    bit v90, v91;
    int ep;
    applyStimulus(4'h5, 1'b0, 1'b0, v90, v91, ep);
    checks++; if (ep != 1)              begin errors++; $display("[TB] FAIL badstop.pulses got=%0d exp=1", ep); end
    checks++; if (rxValid !== expValid) begin errors++; $display("[TB] FAIL badstop.rx_valid got=%b exp=%b", rxValid, expValid); end
    idle(20);
    applyStimulus(4'h6, 1'b1, 1'b0, v90, v91, ep);
    checks++; if (rxData !== expData)   begin errors++; $display("[TB] FAIL badstop.next_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid) begin errors++; $display("[TB] FAIL badstop.next_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (ep != 0)              begin errors++; $display("[TB] FAIL badstop.next_pulses got=%0d exp=0", ep); end
    doAck();
  endtask

  task automatic test_glitch();
    bit v90, v91;
    int ep;
    int busyCycles;
    int errSeen;
    applyStimulus(4'h2, 1'b1, 1'b0, v90, v91, ep);
    idle(4);
    busyCycles = 0;
    errSeen    = 0;
    serialIn   = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (n == 6) serialIn = 1'b1;
      @(posedge clock);
      #1;
      if (busy) busyCycles++;
      if (frameErr) errSeen++;
    end
    checks++; if (busyCycles == 0 || busyCycles >= 10) begin errors++; $display("[TB] FAIL glitch.busy_cycles got=%0d exp=1..9", busyCycles); end
    checks++; if (errSeen != 0)           begin errors++; $display("[TB] FAIL glitch.frame_err got=%0d exp=0", errSeen); end
    checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL glitch.rx_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL glitch.rx_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL glitch.overrun got=%b exp=%b", overrun, expOverrun); end
  endtask

  task automatic test_ack_collision();
    bit v90, v91;
    int ep;
    // Leaves 0x2 from the previous scenario held; consume it so 0x1 is the held word.
    doAck();
    applyStimulus(4'h1, 1'b1, 1'b0, v90, v91, ep);
    applyStimulus(4'h7, 1'b1, 1'b1, v90, v91, ep);
    checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL collide.rx_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL collide.rx_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL collide.overrun got=%b exp=%b", overrun, expOverrun); end
  endtask

  task automatic test_reset_mid_frame();
    bit v90, v91;
    int ep;
    // Word 0x7 is still held here, so the reset has something to clear.
    for (int n = 0; n < 56; n++) begin
      serialIn = frameLevel(4'hF, 1'b1, n);
      @(posedge clock);
      #1;
    end
    #2 resetN = 1'b0;
    expData = '0; expValid = 1'b0; expOverrun = 1'b0;
    #1;
    checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL midreset.rx_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL midreset.rx_valid got=%b exp=%b", rxValid, expValid); end
    checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL midreset.overrun got=%b exp=%b", overrun, expOverrun); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL midreset.busy got=%b exp=0", busy); end
    serialIn = 1'b1;
    idle(3);
    resetN = 1'b1;
    idle(40);
    checks++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL midreset.quiet_busy got=%b exp=0", busy); end
    applyStimulus(4'h9, 1'b1, 1'b0, v90, v91, ep);
    checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL midreset.next_data got=%h exp=%h", rxData, expData); end
    checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL midreset.next_valid got=%b exp=%b", rxValid, expValid); end
    doAck();
  endtask

  task automatic test_random();
    bit v90, v91;
    int ep;
    logic [DB-1:0] word;
    bit stopBit;
    bit ackDone;
    for (int i = 0; i < 12; i++) begin
      word    = 4'($urandom_range(0, 15));
      stopBit = ($urandom_range(0, 4) != 0);
      ackDone = ($urandom_range(0, 3) == 0);
      applyStimulus(word, stopBit, ackDone, v90, v91, ep);
      checks++; if (rxData !== expData)     begin errors++; $display("[TB] FAIL random%0d.rx_data got=%h exp=%h", i, rxData, expData); end
      checks++; if (rxValid !== expValid)   begin errors++; $display("[TB] FAIL random%0d.rx_valid got=%b exp=%b", i, rxValid, expValid); end
      checks++; if (overrun !== expOverrun) begin errors++; $display("[TB] FAIL random%0d.overrun got=%b exp=%b", i, overrun, expOverrun); end
      checks++; if (ep != (stopBit ? 0 : 1)) begin errors++; $display("[TB] FAIL random%0d.frame_err got=%0d exp=%0d", i, ep, stopBit ? 0 : 1); end
      if (!stopBit) idle(20);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) doAck();
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    resetN   = 1'b0;
    serialIn = 1'b1;
    rdAck    = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_stop();
    test_glitch();
    test_ack_collision();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
